// File: rtl/dmem_responder.sv
// +------------------------------------------------------------------------+
// | dmem_responder: data-memory responder with store merge, load extend,   |
// | post-reset zero-clear and sticky misalign flag. Optional perf counters  |
// | enabled by DMEM_PERF_CNT_EN.                                            |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
`default_nettype none

module dmem_responder #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             CS,
  input  logic             DM_W,
  input  logic             DM_R,
  input  logic [1:0]       SC,
  input  logic [2:0]       LC,
  input  logic [31:0]      DMEMaddr,
  input  logic [31:0]      Data_in,
  output logic [31:0]      Dataout,
  output logic             dm_ready,
  output logic             err_misalign,
  output logic [31:0]      err_addr,
  input  logic             clr_err,
  output logic [CNT_W-1:0] rd_cnt,
  output logic [CNT_W-1:0] wr_cnt
);

  typedef enum logic [0:0] {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   init_idx_q, init_idx_d;
  logic            err_q, err_d;
  logic [31:0]     err_addr_q, err_addr_d;

  logic [31:0]     mem [DEPTH];

  logic [AW-1:0]   word_idx;
  logic [1:0]      lo;
  logic            st_legal, ld_legal;
  logic            access, st_ok, ld_ok, illegal;
  logic [3:0]      st_be;
  logic [31:0]     st_data;
  logic [3:0]      mem_be;
  logic [AW-1:0]   mem_widx;
  logic [31:0]     mem_wdata;
  logic [31:0]     rdata;
  logic [7:0]      rd_byte;
  logic [15:0]     rd_half;

  assign word_idx = DMEMaddr[AW+1:2];
  assign lo       = DMEMaddr[1:0];
  assign dm_ready = (state_q == ST_RUN);

  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    case (state_q)
      ST_INIT: begin
        init_idx_d = init_idx_q + 1'b1;
        if (init_idx_q == AW'(DEPTH - 1)) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    st_legal = 1'b0;
    st_be    = 4'b0000;
    st_data  = Data_in;
    case (SC)
      2'b00: begin st_legal = (lo == 2'b00); st_be = 4'b1111; end
      2'b01: begin
        st_legal = ~lo[0];
        st_be    = lo[1] ? 4'b1100 : 4'b0011;
        st_data  = {2{Data_in[15:0]}};
      end
      2'b10: begin
        st_legal = 1'b1;
        st_be    = 4'b0001 << lo;
        st_data  = {4{Data_in[7:0]}};
      end
      default: st_legal = 1'b0;
    endcase
  end

  always_comb begin
    ld_legal = 1'b0;
    case (LC)
      3'b000:         ld_legal = (lo == 2'b00);
      3'b001, 3'b010: ld_legal = ~lo[0];
      3'b011, 3'b100: ld_legal = 1'b1;
      default:        ld_legal = 1'b0;
    endcase
  end

  assign access  = CS & dm_ready;
  assign st_ok   = access & DM_W & st_legal;
  assign ld_ok   = access & DM_R & ld_legal;
  assign illegal = access & ((DM_W & ~st_legal) | (DM_R & ~ld_legal));

  // The init sweep owns the single write port until RUN.
  always_comb begin
    if (state_q == ST_INIT) begin
      mem_be    = 4'b1111;
      mem_widx  = init_idx_q;
      mem_wdata = 32'h0;
    end else begin
      mem_be    = st_ok ? st_be : 4'b0000;
      mem_widx  = word_idx;
      mem_wdata = st_data;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (mem_be[i]) mem[mem_widx][8*i +: 8] <= mem_wdata[8*i +: 8];
    end
  end

  assign rdata   = mem[word_idx];
  assign rd_byte = rdata[8*lo +: 8];
  assign rd_half = lo[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    Dataout = 32'h0;
    if (ld_ok) begin
      case (LC)
        3'b000:  Dataout = rdata;
        3'b001:  Dataout = {{16{rd_half[15]}}, rd_half};
        3'b010:  Dataout = {16'h0, rd_half};
        3'b011:  Dataout = {{24{rd_byte[7]}}, rd_byte};
        3'b100:  Dataout = {24'h0, rd_byte};
        default: Dataout = 32'h0;
      endcase
    end
  end

  // A new illegal access beats a simultaneous clear.
  always_comb begin
    err_d      = err_q;
    err_addr_d = err_addr_q;
    if (clr_err) begin
      err_d      = 1'b0;
      err_addr_d = 32'h0;
    end
    if (illegal) begin
      err_d = 1'b1;
      if (!err_q || clr_err) err_addr_d = DMEMaddr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_INIT;
      init_idx_q <= '0;
      err_q      <= 1'b0;
      err_addr_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      init_idx_q <= init_idx_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign err_misalign = err_q;
  assign err_addr     = err_addr_q;

`ifdef DMEM_PERF_CNT_EN
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (ld_ok && (rd_cnt_q != '1)) rd_cnt_d = rd_cnt_q + 1'b1;
    if (st_ok && (wr_cnt_q != '1)) wr_cnt_d = wr_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign rd_cnt = rd_cnt_q;
  assign wr_cnt = wr_cnt_q;
`else
  assign rd_cnt = '0;
  assign wr_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// Directed table-driven bench for dmem_responder.
`default_nettype none

module tb_dmem_responder;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             CS, DM_W, DM_R, clr_err;
  logic [1:0]       SC;
  logic [2:0]       LC;
  logic [31:0]      DMEMaddr, Data_in;
  logic [31:0]      Dataout;
  logic             dm_ready, err_misalign;
  logic [31:0]      err_addr;
  logic [CNT_W-1:0] rd_cnt, wr_cnt;

  int checks   = 0;
  int failures = 0;

  dmem_responder #(.DEPTH(DEPTH), .AW(AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .CS(CS), .DM_W(DM_W), .DM_R(DM_R),
    .SC(SC), .LC(LC), .DMEMaddr(DMEMaddr), .Data_in(Data_in),
    .Dataout(Dataout), .dm_ready(dm_ready), .err_misalign(err_misalign),
    .err_addr(err_addr), .clr_err(clr_err), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        cs, w, r;
    logic [1:0]  sc;
    logic [2:0]  lc;
    logic [31:0] addr, din;
    logic        clr;
    logic [31:0] exp_dout;
    logic        exp_err;
    logic [31:0] exp_ea;
  } vec_t;

  vec_t vecs[32];

  function automatic vec_t mk(logic cs, logic w, logic r, logic [1:0] sc, logic [2:0] lc,
                              logic [31:0] addr, logic [31:0] din, logic clr,
                              logic [31:0] dout, logic err, logic [31:0] ea);
    vec_t v;
    v.cs = cs; v.w = w; v.r = r; v.sc = sc; v.lc = lc; v.addr = addr; v.din = din;
    v.clr = clr; v.exp_dout = dout; v.exp_err = err; v.exp_ea = ea;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic cs, input logic w, input logic r, input logic [1:0] sc,
                       input logic [2:0] lc, input logic [31:0] addr, input logic [31:0] din,
                       input logic clr);
    CS = cs; DM_W = w; DM_R = r; SC = sc; LC = lc; DMEMaddr = addr; Data_in = din; clr_err = clr;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 1'b0);
  endtask

  // Walks the init sweep; optionally pokes stores that must be ignored.
  task automatic init_run(input bit poke);
    for (int k = 1; k <= DEPTH; k++) begin
      @(posedge clk); #1;
      chk($sformatf("dm_ready_k%0d", k), {31'h0, dm_ready}, (k < DEPTH) ? 32'h0 : 32'h1);
      if (poke && k == 10) drive(1'b1, 1'b1, 1'b0, 2'b00, 3'b000, 32'h0, 32'hFFFFFFFF, 1'b0);
      if (poke && k == 11) drive(1'b1, 1'b1, 1'b0, 2'b00, 3'b000, 32'h2, 32'hFFFFFFFF, 1'b0);
      if (k == 12) idle();
    end
  endtask

  task automatic load(input logic [31:0] addr, input logic [2:0] lc, input logic [31:0] exp,
                      input string name);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 2'b00, lc, addr, 32'h0, 1'b0);
    #1 chk(name, Dataout, exp);
    @(posedge clk); #1;
    idle();
  endtask

  logic [CNT_W-1:0] exp_rd, exp_wr;

  initial begin
    reset = 1'b1;
    idle();
`ifdef DMEM_PERF_CNT_EN
    exp_rd = 21; exp_wr = 5;
`else
    exp_rd = 0; exp_wr = 0;
`endif

    vecs[0]  = mk(1,1,0,2'b00,3'b000,32'h10,  32'h11223344,0, 32'h00000000,0,32'h0);
    vecs[1]  = mk(1,0,1,2'b00,3'b011,32'h13,  32'h0,       0, 32'h00000011,0,32'h0);
    vecs[2]  = mk(1,0,1,2'b00,3'b001,32'h12,  32'h0,       0, 32'h00001122,0,32'h0);
    vecs[3]  = mk(1,0,1,2'b00,3'b100,32'h10,  32'h0,       0, 32'h00000044,0,32'h0);
    vecs[4]  = mk(1,0,1,2'b00,3'b010,32'h10,  32'h0,       0, 32'h00003344,0,32'h0);
    vecs[5]  = mk(1,0,1,2'b00,3'b000,32'h10,  32'h0,       0, 32'h11223344,0,32'h0);
    vecs[6]  = mk(1,1,0,2'b10,3'b000,32'h21,  32'h80,      0, 32'h00000000,0,32'h0);
    vecs[7]  = mk(1,0,1,2'b00,3'b011,32'h21,  32'h0,       0, 32'hFFFFFF80,0,32'h0);
    vecs[8]  = mk(1,0,1,2'b00,3'b100,32'h21,  32'h0,       0, 32'h00000080,0,32'h0);
    vecs[9]  = mk(1,0,1,2'b00,3'b000,32'h20,  32'h0,       0, 32'h00008000,0,32'h0);
    vecs[10] = mk(1,1,0,2'b01,3'b000,32'h22,  32'hABCD8765,0, 32'h00000000,0,32'h0);
    vecs[11] = mk(1,0,1,2'b00,3'b001,32'h22,  32'h0,       0, 32'hFFFF8765,0,32'h0);
    vecs[12] = mk(1,0,1,2'b00,3'b000,32'h20,  32'h0,       0, 32'h87658000,0,32'h0);
    vecs[13] = mk(1,1,1,2'b00,3'b000,32'h30,  32'hDEADBEEF,0, 32'h00000000,0,32'h0);
    vecs[14] = mk(1,0,1,2'b00,3'b000,32'h30,  32'h0,       0, 32'hDEADBEEF,0,32'h0);
    vecs[15] = mk(0,1,1,2'b00,3'b000,32'h10,  32'hFFFFFFFF,0, 32'h00000000,0,32'h0);
    vecs[16] = mk(1,0,1,2'b00,3'b000,32'h10,  32'h0,       0, 32'h11223344,0,32'h0);
    vecs[17] = mk(1,1,0,2'b00,3'b000,32'h42,  32'hFFFFFFFF,0, 32'h00000000,1,32'h42);
    vecs[18] = mk(1,0,1,2'b00,3'b000,32'h40,  32'h0,       0, 32'h00000000,1,32'h42);
    vecs[19] = mk(1,0,1,2'b00,3'b001,32'h45,  32'h0,       0, 32'h00000000,1,32'h42);
    vecs[20] = mk(0,0,0,2'b00,3'b000,32'h0,   32'h0,       1, 32'h00000000,0,32'h0);
    vecs[21] = mk(1,0,1,2'b00,3'b010,32'h47,  32'h0,       1, 32'h00000000,1,32'h47);
    vecs[22] = mk(0,0,0,2'b00,3'b000,32'h0,   32'h0,       1, 32'h00000000,0,32'h0);
    vecs[23] = mk(1,1,0,2'b11,3'b000,32'h50,  32'h5555,    0, 32'h00000000,1,32'h50);
    vecs[24] = mk(1,0,1,2'b00,3'b000,32'h50,  32'h0,       0, 32'h00000000,1,32'h50);
    vecs[25] = mk(0,0,0,2'b00,3'b000,32'h0,   32'h0,       1, 32'h00000000,0,32'h0);
    vecs[26] = mk(1,0,1,2'b00,3'b101,32'h10,  32'h0,       0, 32'h00000000,1,32'h10);
    vecs[27] = mk(0,0,0,2'b00,3'b000,32'h0,   32'h0,       1, 32'h00000000,0,32'h0);
    vecs[28] = mk(1,0,1,2'b00,3'b000,32'h1010,32'h0,       0, 32'h11223344,0,32'h0);
    vecs[29] = mk(1,1,0,2'b10,3'b000,32'h33,  32'h7F,      0, 32'h00000000,0,32'h0);
    vecs[30] = mk(1,0,1,2'b00,3'b011,32'h33,  32'h0,       0, 32'h0000007F,0,32'h0);
    vecs[31] = mk(1,0,1,2'b00,3'b000,32'h30,  32'h0,       0, 32'h7FADBEEF,0,32'h0);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_dm_ready", {31'h0, dm_ready}, 32'h0);
    chk("rst_err", {31'h0, err_misalign}, 32'h0);
    chk("rst_err_addr", err_addr, 32'h0);
    chk("rst_rd_cnt", rd_cnt, 32'h0);
    chk("rst_wr_cnt", wr_cnt, 32'h0);

    @(negedge clk);
    reset = 1'b0;
    init_run(1'b1);

    load(32'h0,   3'b000, 32'h0, "lw_init_0");
    load(32'hFFC, 3'b000, 32'h0, "lw_init_ffc");
    load(32'h800, 3'b000, 32'h0, "lw_init_800");
    chk("init_no_err", {31'h0, err_misalign}, 32'h0);

    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      drive(vecs[i].cs, vecs[i].w, vecs[i].r, vecs[i].sc, vecs[i].lc,
            vecs[i].addr, vecs[i].din, vecs[i].clr);
      #1 chk($sformatf("v%0d_dout", i), Dataout, vecs[i].exp_dout);
      @(posedge clk); #1;
      chk($sformatf("v%0d_err", i), {31'h0, err_misalign}, {31'h0, vecs[i].exp_err});
      chk($sformatf("v%0d_ea", i), err_addr, vecs[i].exp_ea);
    end
    idle();

    chk("rd_cnt", rd_cnt, exp_rd);
    chk("wr_cnt", wr_cnt, exp_wr);

    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst2_dm_ready", {31'h0, dm_ready}, 32'h0);
    chk("rst2_rd_cnt", rd_cnt, 32'h0);
    chk("rst2_wr_cnt", wr_cnt, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    init_run(1'b0);

    load(32'h10, 3'b000, 32'h0, "lw_reclr_10");
    load(32'h20, 3'b000, 32'h0, "lw_reclr_20");
    load(32'h30, 3'b000, 32'h0, "lw_reclr_30");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
